// File: rtl/rr_mux_stream_if.sv
// Handshake bundle for rr_mux_stream: N producer channels in, one registered stream out.
// slave is the mux side, master is the producer/consumer side driving it.
interface rr_mux_stream_if #(
  parameter int N = 8,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/rr_mux_stream.sv
// N:1 streaming multiplexer with round-robin or fixed-channel arbitration
// feeding a single output register (1-cycle latency, 1 beat/cycle sustained).
module rr_mux_stream #(
  parameter int N = 8,
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst,
  rr_mux_stream_if.slave s
);
  localparam int SW = $clog2(N);

  logic [SW-1:0] last_p1;
  logic [SW-1:0] ch_p1;
  logic [W-1:0]  data_p1;
  logic          vld_p1;

  logic          load;
  logic          xfer;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [SW:0]   rr_gnt;

  // Returns {found, index}: first valid channel after 'last', wrapping around.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0] v, input logic [SW-1:0] last);
    logic [SW:0] res;
    int          k;
    res = '0;
    for (int off = N; off >= 1; off--) begin
      k = (int'(last) + off) % N;
      if (v[k]) res = {1'b1, SW'(k)};
    end
    return res;
  endfunction

  // Stage p0: arbitration, combinational from current inputs
  assign load   = ~vld_p1 | s.out_ready;
  assign rr_gnt = rr_pick(s.in_valid, last_p1);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (s.mode) begin
      // An out-of-range sel (non power-of-two N) never grants.
      if (int'(s.sel) < N && s.in_valid[s.sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = s.sel;
      end
    end else begin
      gnt_vld = rr_gnt[SW];
      gnt_idx = rr_gnt[SW-1:0];
    end
  end

  assign xfer       = load & gnt_vld & ~rst;
  assign s.in_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  // Stage p1: output register and last-grant pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      last_p1 <= SW'(N - 1);
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= s.in_data[gnt_idx*W +: W];
      ch_p1   <= gnt_idx;
      last_p1 <= gnt_idx;
    end else if (s.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign s.out_valid = vld_p1;
  assign s.out_data  = data_p1;
  assign s.out_ch    = ch_p1;
endmodule

// File: tb/tb_rr_mux_stream.sv
// Bench for rr_mux_stream: directed vector table, a mode-switch sequence,
// then random traffic against a priority-list reference model.
module tb_rr_mux_stream;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_stream_if #(.N(N), .W(W)) bus ();
  rr_mux_stream #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .s(bus));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic          rst;
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  valid;
    logic          ordy;
    logic [N-1:0]  rdy;
    logic          vld;
    logic [SW-1:0] ch;
    logic [W-1:0]  data;
  } vec_t;

  vec_t tv[31];

  function automatic vec_t mk(input logic r, input logic m, input int sl, input int v,
                              input logic o, input int rd, input logic vl, input int c, input int d);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = SW'(sl); t.valid = N'(v); t.ordy = o;
    t.rdy = N'(rd); t.vld = vl; t.ch = SW'(c); t.data = W'(d);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: build the channel priority list from the rules, take the first valid one.
  function automatic logic [N-1:0] ref_ready(input logic r, input logic md, input logic [SW-1:0] sl,
                                             input logic [N-1:0] v, input logic ordy,
                                             input int last, input logic ovld);
    int order[$];
    logic [N-1:0] one;
    one = 1;
    if (r || (ovld && !ordy)) return '0;
    if (md) begin
      if (int'(sl) < N) order.push_back(int'(sl));
    end else begin
      for (int off = 1; off <= N; off++) order.push_back((last + off) % N);
    end
    foreach (order[i]) if (v[order[i]]) return one << order[i];
    return '0;
  endfunction

  int            m_last;
  logic          m_vld;
  logic [SW-1:0] m_ch;
  logic [W-1:0]  m_data;
  bit            m_known;

  initial begin
    logic [N-1:0] er;
    // Table: inputs applied for one cycle; expected in_ready and current output register.
    tv[0]  = mk(1, 0, 0, 'hFF, 1, 'h00, 0, 0, 'h00);
    tv[1]  = mk(0, 0, 0, 'hFF, 1, 'h01, 0, 0, 'h00);
    tv[2]  = mk(0, 0, 0, 'hFF, 1, 'h02, 1, 0, 'h10);
    tv[3]  = mk(0, 0, 0, 'hFF, 1, 'h04, 1, 1, 'h11);
    tv[4]  = mk(0, 0, 0, 'hFF, 1, 'h08, 1, 2, 'h12);
    tv[5]  = mk(0, 0, 0, 'hFF, 1, 'h10, 1, 3, 'h13);
    tv[6]  = mk(0, 0, 0, 'hFF, 1, 'h20, 1, 4, 'h14);
    tv[7]  = mk(0, 0, 0, 'hFF, 1, 'h40, 1, 5, 'h15);
    tv[8]  = mk(0, 0, 0, 'hFF, 1, 'h80, 1, 6, 'h16);
    tv[9]  = mk(0, 0, 0, 'hFF, 1, 'h01, 1, 7, 'h17);
    tv[10] = mk(0, 0, 0, 'hFF, 1, 'h02, 1, 0, 'h10);
    tv[11] = mk(0, 0, 0, 'h44, 1, 'h04, 1, 1, 'h11);
    tv[12] = mk(0, 0, 0, 'h44, 1, 'h40, 1, 2, 'h12);
    tv[13] = mk(0, 0, 0, 'h44, 1, 'h04, 1, 6, 'h16);
    tv[14] = mk(0, 0, 0, 'h44, 1, 'h40, 1, 2, 'h12);
    tv[15] = mk(0, 0, 0, 'hFF, 0, 'h00, 1, 6, 'h16);
    tv[16] = mk(0, 0, 0, 'hFF, 0, 'h00, 1, 6, 'h16);
    tv[17] = mk(0, 0, 0, 'hFF, 0, 'h00, 1, 6, 'h16);
    tv[18] = mk(0, 0, 0, 'hFF, 1, 'h80, 1, 6, 'h16);
    tv[19] = mk(0, 0, 0, 'hFF, 1, 'h01, 1, 7, 'h17);
    tv[20] = mk(0, 1, 3, 'hFF, 1, 'h08, 1, 0, 'h10);
    tv[21] = mk(0, 1, 3, 'hFF, 1, 'h08, 1, 3, 'h13);
    tv[22] = mk(0, 1, 3, 'hFF, 1, 'h08, 1, 3, 'h13);
    tv[23] = mk(0, 1, 3, 'hF7, 1, 'h00, 1, 3, 'h13);
    tv[24] = mk(0, 1, 3, 'hF7, 1, 'h00, 0, 3, 'h13);
    tv[25] = mk(0, 0, 0, 'hFF, 1, 'h10, 0, 3, 'h13);
    tv[26] = mk(0, 0, 0, 'hFF, 1, 'h20, 1, 4, 'h14);
    tv[27] = mk(0, 0, 0, 'hFF, 0, 'h00, 1, 5, 'h15);
    tv[28] = mk(1, 0, 0, 'hFF, 0, 'h00, 1, 5, 'h15);
    tv[29] = mk(0, 0, 0, 'hFF, 0, 'h01, 0, 0, 'h00);
    tv[30] = mk(0, 0, 0, 'hFF, 1, 'h02, 1, 0, 'h10);

    rst = 1'b1;
    bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '1; bus.out_ready = 1'b1;
    for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = W'(8'h10 + k);

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      rst = tv[i].rst; bus.mode = tv[i].mode; bus.sel = tv[i].sel;
      bus.in_valid = tv[i].valid; bus.out_ready = tv[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i),  32'(bus.in_ready),  32'(tv[i].rdy));
      chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tv[i].vld));
      chk($sformatf("vec%0d out_ch", i),    32'(bus.out_ch),    32'(tv[i].ch));
      chk($sformatf("vec%0d out_data", i),  32'(bus.out_data),  32'(tv[i].data));
    end

    // Mode switch while a beat from ch1 is stalled: held beat unaffected, new mode used on release.
    @(negedge clk);
    bus.mode = 1'b0; bus.in_valid = '1; bus.out_ready = 1'b0; #1;
    chk("hold rr in_ready", 32'(bus.in_ready), 32'h00);
    @(negedge clk);
    bus.mode = 1'b1; bus.sel = SW'(2); #1;
    chk("hold fix in_ready", 32'(bus.in_ready), 32'h00);
    chk("hold fix out_ch", 32'(bus.out_ch), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1; #1;
    chk("release fix in_ready", 32'(bus.in_ready), 32'h04);
    @(negedge clk);
    #1;
    chk("release fix out_data", 32'(bus.out_data), 32'h12);

    // Random traffic against the reference model, starting from a reset.
    m_known = 1'b0;
    m_last = N - 1; m_vld = 1'b0; m_ch = '0; m_data = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst           = (c == 0) || ($urandom_range(0, 39) == 0);
      bus.mode      = ($urandom_range(0, 3) == 0);
      bus.sel       = SW'($urandom);
      bus.in_valid  = N'($urandom) & N'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = W'($urandom);
      #1;
      er = ref_ready(rst, bus.mode, bus.sel, bus.in_valid, bus.out_ready, m_last, m_vld);
      if (m_known) begin
        chk($sformatf("rnd%0d in_ready", c),  32'(bus.in_ready),  32'(er));
        chk($sformatf("rnd%0d out_valid", c), 32'(bus.out_valid), 32'(m_vld));
        chk($sformatf("rnd%0d out_ch", c),    32'(bus.out_ch),    32'(m_ch));
        chk($sformatf("rnd%0d out_data", c),  32'(bus.out_data),  32'(m_data));
      end else begin
        chk("rnd reset in_ready", 32'(bus.in_ready), 32'h00);
      end
      @(posedge clk);
      if (rst) begin
        m_known = 1'b1; m_last = N - 1; m_vld = 1'b0; m_ch = '0; m_data = '0;
      end else if (er != '0) begin
        for (int k = 0; k < N; k++) if (er[k]) begin
          m_last = k; m_ch = SW'(k); m_vld = 1'b1; m_data = bus.in_data[k*W +: W];
        end
      end else if (m_vld && bus.out_ready) begin
        m_vld = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
